// File: rtl/alu_flag_pkg.sv
// alu_flag_pkg: shared types and helpers for the flag-producing ALU.
//   op_t    - 3-bit operation code (ADD..MUL)
//   state_t - control FSM states of alu_flag_unit
//   add_sub_ovf - signed overflow from operand/result sign bits
package alu_flag_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_ORR = 3'b011,
    OP_EOR = 3'b100,
    OP_MOV = 3'b101,
    OP_CMP = 3'b110,
    OP_MUL = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    MUL_RUN = 2'd2
  } state_t;

  // Subtraction is addition of the inverted B, so B's sign is flipped and
  // the add rule applies: same effective sign in, different sign out.
  function automatic logic add_sub_ovf(input logic sa, input logic sb,
                                       input logic sr, input logic sub);
    logic eff_sb;
    eff_sb = sub ? ~sb : sb;
    return (sa == eff_sb) && (sr != sa);
  endfunction

endpackage

// File: rtl/alu_flag_if.sv
// alu_flag_if: request/response bundle between the control FSM (master)
// and the ALU/flag unit (slave).
//   master drives: start, op, set_flags, a, b
//   slave drives:  ready, done, result, wb_en, z, v, n, flag_we
interface alu_flag_if
  import alu_flag_pkg::*;
#(
  parameter int WIDTH = 8
);
  logic             start;
  op_t              op;
  logic             set_flags;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             wb_en;
  logic             z;
  logic             v;
  logic             n;
  logic             flag_we;

  modport master (
    output start, op, set_flags, a, b,
    input  ready, done, result, wb_en, z, v, n, flag_we
  );

  modport slave (
    input  start, op, set_flags, a, b,
    output ready, done, result, wb_en, z, v, n, flag_we
  );
endinterface

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative unsigned shift-add multiplier.
//   clk, rst      - clock, async active-high reset
//   start         - load a/b and begin (one cycle)
//   a, b          - multiplicand / multiplier
//   product       - 2*WIDTH-bit product, final when done pulses
//   done          - one-cycle pulse after WIDTH iterations
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               done
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  // One multiplier bit per cycle, LSB first; the multiplicand shifts left
  // so it is always aligned with the bit being consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc    <= '0;
        mcand  <= {{WIDTH{1'b0}}, a};
        mplier <= b;
        cnt    <= CW'(WIDTH);
      end else if (cnt != '0) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CW'(1);
        done   <= (cnt == CW'(1));
      end
    end
  end

  assign product = acc;

endmodule

// File: rtl/alu_flag_unit.sv
// alu_flag_unit: multi-cycle integer ALU producing result and z/v/n flags
// with a one-cycle flag-write strobe for the conditional unit.
//   clk, rst - clock, async active-high reset
//   bus      - alu_flag_if slave: start/op/set_flags/a/b in;
//              ready/done/result/wb_en/z/v/n/flag_we out (all registered)
module alu_flag_unit
  import alu_flag_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  alu_flag_if.slave   bus
);
  state_t             state;
  op_t                op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               sf_q;

  logic               ready_q;
  logic               done_q;
  logic [WIDTH-1:0]   result_q;
  logic               wb_en_q;
  logic               z_q;
  logic               v_q;
  logic               n_q;
  logic               flag_we_q;

  logic               mul_start;
  logic [2*WIDTH-1:0] mul_prod;
  logic               mul_done;

  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   res_raw;
  logic               v_raw;
  logic               finish;

  // The multiplier loads straight from the bus on the acceptance edge so
  // its WIDTH iterations overlap the MUL_RUN state exactly.
  assign mul_start = (state == IDLE) && bus.start && (bus.op == OP_MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (bus.a),
    .b       (bus.b),
    .product (mul_prod),
    .done    (mul_done)
  );

  always_comb begin
    sum     = a_q + b_q;
    diff    = a_q - b_q;
    res_raw = '0;
    v_raw   = 1'b0;
    case (op_q)
      OP_ADD: begin
        res_raw = sum;
        v_raw   = add_sub_ovf(a_q[WIDTH-1], b_q[WIDTH-1], sum[WIDTH-1], 1'b0);
      end
      OP_SUB, OP_CMP: begin
        res_raw = diff;
        v_raw   = add_sub_ovf(a_q[WIDTH-1], b_q[WIDTH-1], diff[WIDTH-1], 1'b1);
      end
      OP_AND: res_raw = a_q & b_q;
      OP_ORR: res_raw = a_q | b_q;
      OP_EOR: res_raw = a_q ^ b_q;
      OP_MOV: res_raw = b_q;
      OP_MUL: begin
        res_raw = mul_prod[WIDTH-1:0];
        v_raw   = |mul_prod[2*WIDTH-1:WIDTH];
      end
      default: begin
        res_raw = '0;
        v_raw   = 1'b0;
      end
    endcase
  end

  assign finish = (state == EXEC) || ((state == MUL_RUN) && mul_done);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= OP_ADD;
      a_q       <= '0;
      b_q       <= '0;
      sf_q      <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      result_q  <= '0;
      wb_en_q   <= 1'b0;
      z_q       <= 1'b0;
      v_q       <= 1'b0;
      n_q       <= 1'b0;
      flag_we_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      flag_we_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q    <= bus.op;
            a_q     <= bus.a;
            b_q     <= bus.b;
            sf_q    <= bus.set_flags;
            ready_q <= 1'b0;
            state   <= (bus.op == OP_MUL) ? MUL_RUN : EXEC;
          end
        end
        EXEC, MUL_RUN: begin
          if (finish) begin
            state    <= IDLE;
            ready_q  <= 1'b1;
            done_q   <= 1'b1;
            result_q <= res_raw;
            wb_en_q  <= (op_q != OP_CMP);
            if (sf_q || (op_q == OP_CMP)) begin
              flag_we_q <= 1'b1;
              z_q       <= (res_raw == '0);
              n_q       <= res_raw[WIDTH-1];
              v_q       <= v_raw;
            end
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready   = ready_q;
  assign bus.done    = done_q;
  assign bus.result  = result_q;
  assign bus.wb_en   = wb_en_q;
  assign bus.z       = z_q;
  assign bus.v       = v_q;
  assign bus.n       = n_q;
  assign bus.flag_we = flag_we_q;

endmodule

// File: tb/tb_alu_flag_unit.sv
module tb_alu_flag_unit;
  import alu_flag_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_flag_if #(.WIDTH(W)) bus ();

  alu_flag_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int   m_ready = 1, m_done = 0, m_res = 0, m_wb = 0;
  int   m_z = 0, m_v = 0, m_n = 0, m_fwe = 0;
  bit   busy = 0;
  int   rem = 0;
  op_t  p_op;
  int   p_a, p_b;
  bit   p_sf;

  function automatic int sx(input int x);
    return (x > 127) ? x - 256 : x;
  endfunction

  task automatic evaluate(input op_t o, input int x, input int y,
                          output int r, output int ov);
    int s;
    ov = 0;
    case (o)
      OP_ADD: begin s = sx(x) + sx(y); r = (x + y) & 255; ov = int'(s > 127 || s < -128); end
      OP_SUB, OP_CMP: begin s = sx(x) - sx(y); r = (x - y) & 255; ov = int'(s > 127 || s < -128); end
      OP_AND: r = x & y;
      OP_ORR: r = x | y;
      OP_EOR: r = x ^ y;
      OP_MOV: r = y;
      default: begin s = x * y; r = s & 255; ov = int'(s > 255); end
    endcase
  endtask

  always @(posedge clk or posedge rst) begin
    int r, ov;
    bit was_idle;
    if (rst) begin
      busy = 0; rem = 0;
      m_ready = 1; m_done = 0; m_res = 0; m_wb = 0;
      m_z = 0; m_v = 0; m_n = 0; m_fwe = 0;
    end else begin
      was_idle = !busy;
      m_done = 0;
      m_fwe  = 0;
      if (busy) begin
        rem--;
        if (rem == 0) begin
          busy = 0;
          evaluate(p_op, p_a, p_b, r, ov);
          m_done = 1;
          m_res  = r;
          m_wb   = (p_op == OP_CMP) ? 0 : 1;
          if (p_sf || p_op == OP_CMP) begin
            m_fwe = 1;
            m_z = (r == 0) ? 1 : 0;
            m_n = (r > 127) ? 1 : 0;
            m_v = ov;
          end
        end
      end
      if (was_idle && bus.start) begin
        busy = 1;
        p_op = bus.op; p_a = int'(bus.a); p_b = int'(bus.b); p_sf = bus.set_flags;
        rem  = (p_op == OP_MUL) ? W + 1 : 1;
      end
      m_ready = busy ? 0 : 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready",   int'(bus.ready),   m_ready);
      chk("done",    int'(bus.done),    m_done);
      chk("flag_we", int'(bus.flag_we), m_fwe);
      chk("z",       int'(bus.z),       m_z);
      chk("v",       int'(bus.v),       m_v);
      chk("n",       int'(bus.n),       m_n);
      chk("result",  int'(bus.result),  m_res);
      chk("wb_en",   int'(bus.wb_en),   m_wb);
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input op_t o, input int x, input int y, input bit sf);
    bus.op = o; bus.a = 8'(x); bus.b = 8'(y); bus.set_flags = sf;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int lat);
    lat = 0;
    while (!bus.done && lat < budget) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.done) chk("done_timeout", 0, 1);
  endtask

  task automatic pin(input string name, input int lat, input int exp_lat,
                     input int res, input int z, input int n, input int v,
                     input int fwe, input int wb);
    chk({name, "_lat"}, lat, exp_lat);
    chk({name, "_res"}, int'(bus.result), res);
    chk({name, "_z"},   int'(bus.z), z);
    chk({name, "_n"},   int'(bus.n), n);
    chk({name, "_v"},   int'(bus.v), v);
    chk({name, "_fwe"}, int'(bus.flag_we), fwe);
    chk({name, "_wb"},  int'(bus.wb_en), wb);
  endtask

  initial begin
    int lat, dcount;
    bus.start = 1'b0; bus.op = OP_ADD; bus.a = '0; bus.b = '0; bus.set_flags = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready",  int'(bus.ready), 1);
    chk("rst_done",   int'(bus.done), 0);
    chk("rst_result", int'(bus.result), 0);
    chk("rst_flags",  int'({bus.z, bus.v, bus.n, bus.flag_we, bus.wb_en}), 0);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    issue(OP_ADD, 8'h05, 8'hFB, 1); wait_done(20, lat);
    pin("add_zero", lat, 1, 8'h00, 1, 0, 0, 1, 1);
    @(negedge clk);
    issue(OP_ADD, 8'h7F, 8'h01, 1); wait_done(20, lat);
    pin("add_ovf", lat, 1, 8'h80, 0, 1, 1, 1, 1);
    @(negedge clk);
    issue(OP_AND, 8'hF0, 8'h0F, 0); wait_done(20, lat);
    pin("and_noflag", lat, 1, 8'h00, 0, 1, 1, 0, 1);
    @(negedge clk);
    issue(OP_CMP, 8'h03, 8'h03, 0); wait_done(20, lat);
    pin("cmp_eq", lat, 1, 8'h00, 1, 0, 0, 1, 0);
    @(negedge clk);
    issue(OP_MUL, 12, 11, 1);
    chk("mul_busy", int'(bus.ready), 0);
    wait_done(40, lat);
    pin("mul_12x11", lat, W + 1, 8'h84, 0, 1, 0, 1, 1);
    @(negedge clk);
    issue(OP_MUL, 16, 16, 1); wait_done(40, lat);
    pin("mul_trunc", lat, W + 1, 8'h00, 1, 0, 1, 1, 1);
    @(negedge clk);

    // start pulse during a MUL must be ignored
    issue(OP_MUL, 3, 5, 0);
    repeat (2) @(negedge clk);
    issue(OP_SUB, 1, 2, 1);
    wait_done(40, lat);
    pin("mul_ign", lat + 3, W + 1, 8'h0F, 1, 0, 1, 0, 1);
    // new op issued on the done cycle
    issue(OP_SUB, 1, 2, 1); wait_done(20, lat);
    pin("sub_b2b", lat, 1, 8'hFF, 0, 1, 0, 1, 1);
    @(negedge clk);

    issue(OP_SUB, 8'h80, 8'h01, 1); wait_done(20, lat);
    pin("sub_ovf", lat, 1, 8'h7F, 0, 0, 1, 1, 1);
    @(negedge clk);
    issue(OP_MUL, 255, 255, 1); wait_done(40, lat);
    pin("mul_ff", lat, W + 1, 8'h01, 0, 0, 1, 1, 1);
    @(negedge clk);
    issue(OP_ORR, 8'hA0, 8'h05, 1); wait_done(20, lat); @(negedge clk);
    issue(OP_EOR, 8'hFF, 8'h0F, 1); wait_done(20, lat); @(negedge clk);
    issue(OP_MOV, 8'h00, 8'h9C, 0); wait_done(20, lat); @(negedge clk);
    issue(OP_ADD, 8'h80, 8'h80, 1); wait_done(20, lat); @(negedge clk);
    issue(OP_CMP, 8'h7F, 8'hFF, 0); wait_done(20, lat); @(negedge clk);

    // reset in the middle of a MUL aborts it silently
    issue(OP_MUL, 12, 11, 1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_ready",  int'(bus.ready), 1);
    chk("abort_done",   int'(bus.done), 0);
    chk("abort_result", int'(bus.result), 0);
    chk("abort_flags",  int'({bus.z, bus.v, bus.n, bus.flag_we}), 0);
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done) dcount++;
    end
    chk("abort_no_done", dcount, 0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

endmodule
